// File: rtl/regfile_sb_if.sv
// Bundle of write, issue and read-port signals between the pipeline and regfile_sb.
`default_nettype none

interface regfile_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic                     we0;
  logic [ADDR_W-1:0]        waddr0;
  logic [DATA_W-1:0]        wdata0;
  logic                     we1;
  logic [ADDR_W-1:0]        waddr1;
  logic [DATA_W-1:0]        wdata1;
  logic                     iss_en;
  logic [ADDR_W-1:0]        iss_addr;
  logic [NUM_RD*ADDR_W-1:0] raddr;
  logic [NUM_RD*DATA_W-1:0] rdata;
  logic [NUM_RD-1:0]        rbusy;
  logic                     any_busy;

  modport master (
    output we0, waddr0, wdata0, we1, waddr1, wdata1, iss_en, iss_addr, raddr,
    input  rdata, rbusy, any_busy
  );

  modport slave (
    input  we0, waddr0, wdata0, we1, waddr1, wdata1, iss_en, iss_addr, raddr,
    output rdata, rbusy, any_busy
  );
endinterface

`default_nettype wire

// File: rtl/regfile_sb.sv
// regfile_sb: dual-writeback register file with write-through bypass and busy scoreboard.
// Rev 1.0
`default_nettype none

module regfile_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  regfile_sb_if.slave bus
);
  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] r_rf [DEPTH];
  logic [DEPTH-1:0]  r_busy;
  logic [DEPTH-1:0]  w_busy_nxt;
  logic              w_wr0;
  logic              w_wr1;
  logic              w_iss;

  // Register 0 is hardwired: writes and issues to it are dropped here.
  assign w_wr0 = bus.we0    && (bus.waddr0   != '0);
  assign w_wr1 = bus.we1    && (bus.waddr1   != '0);
  assign w_iss = bus.iss_en && (bus.iss_addr != '0);

  always_comb begin
    w_busy_nxt = r_busy;
    if (w_wr0) w_busy_nxt[bus.waddr0] = 1'b0;
    if (w_wr1) w_busy_nxt[bus.waddr1] = 1'b0;
    // A newly issued producer supersedes the one being written back.
    if (w_iss) w_busy_nxt[bus.iss_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_rf[i] <= '0;
      end
      r_busy <= '0;
    end else begin
      if (w_wr0) r_rf[bus.waddr0] <= bus.wdata0;
      // Memory pipe carries the younger instruction, so it lands last.
      if (w_wr1) r_rf[bus.waddr1] <= bus.wdata1;
      r_busy <= w_busy_nxt;
    end
  end

  assign bus.any_busy = |r_busy;

  generate
    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      logic [ADDR_W-1:0] w_ra;
      logic              w_hit0;
      logic              w_hit1;

      assign w_ra   = bus.raddr[k*ADDR_W +: ADDR_W];
      assign w_hit0 = w_wr0 && (bus.waddr0 == w_ra);
      assign w_hit1 = w_wr1 && (bus.waddr1 == w_ra);

      assign bus.rdata[k*DATA_W +: DATA_W] =
        (!rst_n || (w_ra == '0)) ? '0          :
        w_hit1                   ? bus.wdata1  :
        w_hit0                   ? bus.wdata0  :
                                   r_rf[w_ra];

      // A result arriving this cycle is forwarded, so it never stalls issue.
      assign bus.rbusy[k] = rst_n && r_busy[w_ra] && !(w_hit0 || w_hit1);
    end
  endgenerate
endmodule

`default_nettype wire

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb with an expected-value scoreboard queue.
`default_nettype none

module tb_regfile_sb;
  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  regfile_sb_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) bus ();

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  b;
    logic        any;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];

  task automatic idle();
    bus.we0 = 1'b0; bus.waddr0 = '0; bus.wdata0 = '0;
    bus.we1 = 1'b0; bus.waddr1 = '0; bus.wdata1 = '0;
    bus.iss_en = 1'b0; bus.iss_addr = '0;
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    bus.raddr = {a1, a0};
  endtask

  task automatic push(input string tag, input logic [31:0] d0, input logic [31:0] d1,
                      input logic [1:0] b, input logic any);
    exp_t e;
    e.d0 = d0; e.d1 = d1; e.b = b; e.any = any;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic compare();
    exp_t  e;
    string t;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty observed=0 entries expected>=1");
      return;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    checks++;
    assert (bus.rdata[31:0] === e.d0) else begin
      errors++;
      $error("FAIL %s rdata0 observed=%h expected=%h", t, bus.rdata[31:0], e.d0);
    end
    checks++;
    assert (bus.rdata[63:32] === e.d1) else begin
      errors++;
      $error("FAIL %s rdata1 observed=%h expected=%h", t, bus.rdata[63:32], e.d1);
    end
    checks++;
    assert (bus.rbusy === e.b) else begin
      errors++;
      $error("FAIL %s rbusy observed=%b expected=%b", t, bus.rbusy, e.b);
    end
    checks++;
    assert (bus.any_busy === e.any) else begin
      errors++;
      $error("FAIL %s any_busy observed=%b expected=%b", t, bus.any_busy, e.any);
    end
  endtask

  task automatic sample();
    @(negedge clk);
    compare();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin
    idle();
    rd(5'd0, 5'd0);
    rst_n = 1'b1;
    #3 rst_n = 1'b0;

    // Write/issue attempts while in reset must be ignored and not bypassed.
    bus.we0 = 1'b1; bus.waddr0 = 5'd5; bus.wdata0 = 32'hDEADBEEF;
    bus.iss_en = 1'b1; bus.iss_addr = 5'd6;
    rd(5'd5, 5'd6);
    push("reset_hold", 32'h0, 32'h0, 2'b00, 1'b0);
    sample();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle();
    rd(5'd5, 5'd6);
    push("after_reset", 32'h0, 32'h0, 2'b00, 1'b0);
    sample();

    step();
    bus.we0 = 1'b1; bus.waddr0 = 5'd5; bus.wdata0 = 32'hDEADBEEF;
    rd(5'd5, 5'd0);
    push("wr_r5_bypass", 32'hDEADBEEF, 32'h0, 2'b00, 1'b0);
    sample();
    step();
    rd(5'd5, 5'd0);
    push("rd_r5_store", 32'hDEADBEEF, 32'h0, 2'b00, 1'b0);
    sample();

    step();
    bus.we0 = 1'b1; bus.waddr0 = 5'd7; bus.wdata0 = 32'h11111111;
    bus.we1 = 1'b1; bus.waddr1 = 5'd7; bus.wdata1 = 32'h22222222;
    rd(5'd7, 5'd7);
    push("dual_wr_bypass", 32'h22222222, 32'h22222222, 2'b00, 1'b0);
    sample();
    step();
    rd(5'd7, 5'd7);
    push("dual_wr_store", 32'h22222222, 32'h22222222, 2'b00, 1'b0);
    sample();

    step();
    bus.iss_en = 1'b1; bus.iss_addr = 5'd9;
    rd(5'd9, 5'd0);
    push("iss_r9_cycle", 32'h0, 32'h0, 2'b00, 1'b0);
    sample();
    step();
    rd(5'd9, 5'd9);
    push("r9_busy", 32'h0, 32'h0, 2'b11, 1'b1);
    sample();
    step();
    step();
    bus.we0 = 1'b1; bus.waddr0 = 5'd9; bus.wdata0 = 32'h5A5A5A5A;
    rd(5'd9, 5'd9);
    push("r9_wb_bypass", 32'h5A5A5A5A, 32'h5A5A5A5A, 2'b00, 1'b1);
    sample();
    step();
    rd(5'd9, 5'd9);
    push("r9_cleared", 32'h5A5A5A5A, 32'h5A5A5A5A, 2'b00, 1'b0);
    sample();

    step();
    bus.iss_en = 1'b1; bus.iss_addr = 5'd3;
    bus.we1 = 1'b1; bus.waddr1 = 5'd3; bus.wdata1 = 32'hCAFEF00D;
    rd(5'd3, 5'd0);
    push("iss_wb_r3_cycle", 32'hCAFEF00D, 32'h0, 2'b00, 1'b0);
    sample();
    step();
    rd(5'd3, 5'd0);
    push("iss_wins_r3", 32'hCAFEF00D, 32'h0, 2'b01, 1'b1);
    sample();

    step();
    bus.iss_en = 1'b1; bus.iss_addr = 5'd0;
    bus.we0 = 1'b1; bus.waddr0 = 5'd0; bus.wdata0 = 32'hFFFFFFFF;
    rd(5'd0, 5'd3);
    push("r0_cycle", 32'h0, 32'hCAFEF00D, 2'b10, 1'b1);
    sample();
    step();
    rd(5'd0, 5'd3);
    push("r0_after", 32'h0, 32'hCAFEF00D, 2'b10, 1'b1);
    sample();

    step();
    bus.we1 = 1'b1; bus.waddr1 = 5'd3; bus.wdata1 = 32'h00000077;
    rd(5'd3, 5'd3);
    push("wb1_r3_bypass", 32'h77, 32'h77, 2'b00, 1'b1);
    sample();
    step();
    rd(5'd3, 5'd3);
    push("wb1_r3_cleared", 32'h77, 32'h77, 2'b00, 1'b0);
    sample();

    step();
    bus.we0 = 1'b1; bus.waddr0 = 5'd4; bus.wdata0 = 32'h00001234;
    step();
    bus.iss_en = 1'b1; bus.iss_addr = 5'd4;
    step();
    rd(5'd4, 5'd4);
    push("r4_busy", 32'h1234, 32'h1234, 2'b11, 1'b1);
    sample();
    #2 rst_n = 1'b0;
    #1;
    push("async_reset", 32'h0, 32'h0, 2'b00, 1'b0);
    compare();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rd(5'd4, 5'd7);
    push("post_reset_rd", 32'h0, 32'h0, 2'b00, 1'b0);
    sample();

    checks++;
    assert (exp_q.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

`default_nettype wire
